// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, fixed-latency response.
// Does the lane alignment, load extension and misalignment/range/mode checks for the core MEM stage.
module dmem_responder #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_mode,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = WIDTH / 8;
  localparam logic [WIDTH:0] BYTE_LIMIT = (WIDTH+1)'(DEPTH * 4);

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [2:0]         mode_q;
  logic [WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic               accept_c;
  logic               access_c;

  logic [WIDTH-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]   idx_c;
  logic [WIDTH-1:0]   word_c;
  logic [WIDTH-1:0]   shifted_c;
  logic [WIDTH-1:0]   load_c;
  logic [WIDTH-1:0]   wdata_sh_c;
  logic [LANES-1:0]   be_c;
  logic               range_err_c;
  logic               mode_err_c;
  logic               err_c;

  // State register, latency counter and latched request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_c) begin
        we_q    <= req_we;
        mode_q  <= req_mode;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Next-state logic; access_c marks the WAIT->RESP edge where the memory is touched
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    access_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_WAIT;
          cnt_d    = CNT_W'(LATENCY - 1);
          accept_c = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_RESP;
          access_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Access checks: range uses the full address, no wrap-around
  always_comb begin
    range_err_c = ({1'b0, addr_q} >= BYTE_LIMIT);
    mode_err_c  = 1'b0;
    case (mode_q)
      MODE_B:  mode_err_c = 1'b0;
      MODE_H:  mode_err_c = addr_q[0];
      MODE_W:  mode_err_c = (addr_q[1:0] != 2'b00);
      MODE_BU: mode_err_c = we_q;
      MODE_HU: mode_err_c = we_q | addr_q[0];
      default: mode_err_c = 1'b1;
    endcase
    err_c = range_err_c | mode_err_c;
  end

  // Load path: select lane and extend
  always_comb begin
    idx_c     = addr_q[IDX_W+1:2];
    word_c    = mem[idx_c];
    shifted_c = word_c >> {addr_q[1:0], 3'b000};
    load_c    = '0;
    case (mode_q)
      MODE_B:  load_c = {{(WIDTH-8){shifted_c[7]}}, shifted_c[7:0]};
      MODE_BU: load_c = {{(WIDTH-8){1'b0}}, shifted_c[7:0]};
      MODE_H:  load_c = {{(WIDTH-16){shifted_c[15]}}, shifted_c[15:0]};
      MODE_HU: load_c = {{(WIDTH-16){1'b0}}, shifted_c[15:0]};
      MODE_W:  load_c = word_c;
      default: load_c = '0;
    endcase
  end

  // Store path: move right-aligned data to its lanes and build byte enables
  always_comb begin
    wdata_sh_c = wdata_q << {addr_q[1:0], 3'b000};
    be_c       = '0;
    case (mode_q)
      MODE_B:  be_c = LANES'(1) << addr_q[1:0];
      MODE_H:  be_c = LANES'(3) << addr_q[1:0];
      MODE_W:  be_c = '1;
      default: be_c = '0;
    endcase
  end

  // Memory array is intentionally not reset
  always_ff @(posedge clk) begin
    if (access_c && we_q && !err_c) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (be_c[l]) begin
          mem[idx_c][l*8 +: 8] <= wdata_sh_c[l*8 +: 8];
        end
      end
    end
  end

  // Registered outputs follow the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);
      rsp_valid <= (state_d == S_RESP);
      if (access_c) begin
        rsp_rdata <= (err_c || we_q) ? '0 : load_c;
        rsp_err   <= err_c;
      end else if (state_d == S_IDLE) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule
